// File: rtl/stim_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stim_pkg : shared state encoding, pattern modes and LFSR tap table
// Rev 1.0
// ----------------------------------------------------------------------------
package stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int MODE_BIN  = 0;
  localparam int MODE_GRAY = 1;
  localparam int MODE_LFSR = 2;

  // Fibonacci feedback masks for maximal-length sequences, indexed by width.
  localparam logic [7:0] LFSR_TAPS [2:8] = '{
    8'h03, 8'h06, 8'h0C, 8'h14, 8'h30, 8'h60, 8'hB8
  };

  function automatic int unsigned num_vectors(input int unsigned width, input int mode);
    return (mode == MODE_LFSR) ? ((32'd1 << width) - 32'd1) : (32'd1 << width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stim_pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stim_pattern_gen : vector for the upcoming cycle (binary, Gray or LFSR)
// Rev 1.0
// ----------------------------------------------------------------------------
module stim_pattern_gen
  import stim_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] idx_i,
  output logic [WIDTH-1:0] vec_o
);

  generate
    if (MODE == MODE_LFSR) begin : g_lfsr
      localparam logic [7:0]       TAPS_FULL = LFSR_TAPS[WIDTH];
      localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
      localparam logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1};

      logic [WIDTH-1:0] lfsr_q;
      logic [WIDTH-1:0] lfsr_d;
      logic             w_unused_idx;

      assign w_unused_idx = ^idx_i;

      always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
          lfsr_d = SEED;
        end else if (advance_i) begin
          lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          lfsr_q <= SEED;
        end else begin
          lfsr_q <= lfsr_d;
        end
      end

      // Look-ahead value so the sequencer can register it on the same edge.
      assign vec_o = lfsr_d;
    end else if (MODE == MODE_GRAY) begin : g_gray
      logic w_unused_ctl;
      assign w_unused_ctl = ^{clk_i, rst_ni, load_i, advance_i};
      assign vec_o        = idx_i ^ (idx_i >> 1);
    end else begin : g_bin
      logic w_unused_ctl;
      assign w_unused_ctl = ^{clk_i, rst_ni, load_i, advance_i};
      assign vec_o        = idx_i;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/stim_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stim_sequencer : IDLE/INIT/RUN/DONE stimulus sequencer with hold and pause
// Rev 1.0
// ----------------------------------------------------------------------------
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOLD     = 3,
  parameter int INIT_CYC = 2,
  parameter int MODE     = 0
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iStart,
  input  logic             iPause,
  output logic [WIDTH-1:0] oVec,
  output logic             oValid,
  output logic             oInit,
  output logic             oDone
);

  localparam int unsigned      NVEC      = num_vectors(WIDTH, MODE);
  localparam logic [WIDTH-1:0] LAST_IDX  = WIDTH'(NVEC - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
  localparam logic [7:0]       INIT_LAST = 8'(INIT_CYC - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] idx_q;
  logic [WIDTH-1:0] idx_d;
  logic [WIDTH-1:0] vec_q;
  logic             valid_q;
  logic             init_q;
  logic             done_q;

  logic             w_hold_end;
  logic             w_last_vec;
  logic             w_restart;
  logic             w_advance;
  logic [WIDTH-1:0] w_gen_vec;

  always_comb begin
    w_hold_end = (cnt_q == HOLD_LAST);
    w_last_vec = (idx_q == LAST_IDX);
    w_restart  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && iStart;
    w_advance  = (state_q == ST_RUN) && !iPause && w_hold_end && !w_last_vec;
    idx_d      = idx_q;
    if (w_advance) begin
      idx_d = idx_q + 1'b1;
    end else if ((state_q == ST_RUN) && !iPause && w_hold_end) begin
      idx_d = '0;
    end
  end

  stim_pattern_gen #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_pattern_gen (
    .clk_i     (iClk),
    .rst_ni    (iClr),
    .load_i    (w_restart),
    .advance_i (w_advance),
    .idx_i     (idx_d),
    .vec_o     (w_gen_vec)
  );

  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      init_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (iStart) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            vec_q   <= '0;
            init_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_INIT: begin
          if (!iPause) begin
            if (cnt_q == INIT_LAST) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
              init_q  <= 1'b0;
              valid_q <= 1'b1;
              vec_q   <= w_gen_vec;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ST_RUN: begin
          // A paused cycle is not a hold cycle, so oValid drops with it.
          if (iPause) begin
            valid_q <= 1'b0;
          end else begin
            valid_q <= 1'b1;
            if (w_hold_end) begin
              cnt_q <= '0;
              if (w_last_vec) begin
                state_q <= ST_DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                vec_q <= w_gen_vec;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oVec   = vec_q;
  assign oValid = valid_q;
  assign oInit  = init_q;
  assign oDone  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stim_sequencer : scoreboard bench for binary, Gray and LFSR sequencers
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stim_sequencer;

  logic clk;
  logic rst_n;
  logic start;
  logic pause;
  int   sel;

  logic [3:0] vec0;
  logic [2:0] vec1;
  logic [3:0] vec2;
  logic       valid0, valid1, valid2;
  logic       init0, init1, init2;
  logic       done0, done1, done2;

  logic [7:0] m_vec;
  logic       m_valid, m_init, m_done;

  logic [31:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          init_cnt, valid_cnt, run_len, pause_cnt;
  bit          run_on;
  bit          mon_en  = 1'b0;
  bit          lfsr_mode = 1'b0;
  logic [7:0]  last_vec;
  bit [255:0]  seen;

  stim_sequencer u_dut_def (
    .iClk   (clk),
    .iClr   (rst_n),
    .iStart (start && (sel == 0)),
    .iPause (pause && (sel == 0)),
    .oVec   (vec0),
    .oValid (valid0),
    .oInit  (init0),
    .oDone  (done0)
  );

  stim_sequencer #(.WIDTH(3), .HOLD(1), .INIT_CYC(2), .MODE(1)) u_dut_gray (
    .iClk   (clk),
    .iClr   (rst_n),
    .iStart (start && (sel == 1)),
    .iPause (pause && (sel == 1)),
    .oVec   (vec1),
    .oValid (valid1),
    .oInit  (init1),
    .oDone  (done1)
  );

  stim_sequencer #(.WIDTH(4), .HOLD(1), .INIT_CYC(2), .MODE(2)) u_dut_lfsr (
    .iClk   (clk),
    .iClr   (rst_n),
    .iStart (start && (sel == 2)),
    .iPause (pause && (sel == 2)),
    .oVec   (vec2),
    .oValid (valid2),
    .oInit  (init2),
    .oDone  (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_vec   = {4'b0, vec0};
    m_valid = valid0;
    m_init  = init0;
    m_done  = done0;
    if (sel == 1) begin
      m_vec   = {5'b0, vec1};
      m_valid = valid1;
      m_init  = init1;
      m_done  = done1;
    end else if (sel == 2) begin
      m_vec   = {4'b0, vec2};
      m_valid = valid2;
      m_init  = init2;
      m_done  = done2;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_init) init_cnt++;
      if (m_valid) begin
        run_on = 1'b1;
        valid_cnt++;
        last_vec = m_vec;
        if (lfsr_mode) begin
          check_eq("lfsr_nonzero", {31'b0, (m_vec != 8'd0)}, 32'd1);
          if (valid_cnt == 1) check_eq("lfsr_first", m_vec, 32'd1);
          check_eq("lfsr_repeat", {31'b0, seen[m_vec]}, 32'd0);
          seen[m_vec] = 1'b1;
        end else if (sb.size() == 0) begin
          check_eq("sb_underrun", sb.size(), 32'd1);
        end else begin
          check_eq("vec", m_vec, sb.pop_front());
        end
      end else if (run_on && !m_done && !m_init) begin
        pause_cnt++;
        check_eq("pause_hold_vec", m_vec, last_vec);
      end
      if (run_on && !m_done) run_len++;
    end
  end

  task automatic arm();
    init_cnt  = 0;
    valid_cnt = 0;
    run_len   = 0;
    pause_cnt = 0;
    run_on    = 1'b0;
    seen      = '0;
    mon_en    = 1'b1;
  endtask

  task automatic push_def();
    for (int v = 0; v < 16; v++) begin
      for (int h = 0; h < 3; h++) sb.push_back(v);
    end
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!m_done && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    #1;
    check_eq("done_seen", m_done, 32'd1);
  endtask

  task automatic end_checks(input int e_init, input int e_valid, input int e_run,
                            input int e_pause, input logic [7:0] e_last);
    check_eq("init_cycles", init_cnt, e_init);
    check_eq("valid_cycles", valid_cnt, e_valid);
    check_eq("run_cycles", run_len, e_run);
    check_eq("pause_cycles", pause_cnt, e_pause);
    check_eq("sb_leftover", sb.size(), 32'd0);
    check_eq("done_valid", m_valid, 32'd0);
    check_eq("done_vec", m_vec, e_last);
  endtask

  initial begin
    logic [31:0] gray_tab [8];
    int          n4;
    int          guard;
    gray_tab = '{0, 1, 3, 2, 6, 7, 5, 4};

    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    sel   = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_vec", m_vec, 32'd0);
    check_eq("rst_valid", m_valid, 32'd0);
    check_eq("rst_init", m_init, 32'd0);
    check_eq("rst_done", m_done, 32'd0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("idle_valid", m_valid, 32'd0);
    check_eq("idle_init", m_init, 32'd0);
    check_eq("idle_done", m_done, 32'd0);

    // Plain default run
    arm();
    push_def();
    do_start();
    check_eq("start_init", m_init, 32'd1);
    check_eq("start_done", m_done, 32'd0);
    wait_done(200);
    end_checks(2, 48, 48, 0, 8'd15);

    // Restart from DONE with stray start pulses mid-run
    arm();
    push_def();
    do_start();
    check_eq("restart_done_fall", m_done, 32'd0);
    check_eq("restart_init", m_init, 32'd1);
    repeat (20) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(200);
    end_checks(2, 48, 48, 0, 8'd15);

    // Pause for 5 cycles during the second hold cycle of vector 4
    arm();
    push_def();
    do_start();
    n4    = 0;
    guard = 0;
    while ((n4 < 2) && (guard < 200)) begin
      @(negedge clk);
      guard++;
      if (m_valid && (m_vec == 8'd4)) n4++;
    end
    check_eq("pause_found_v4", n4, 32'd2);
    pause = 1'b1;
    repeat (5) @(posedge clk);
    #1 pause = 1'b0;
    wait_done(200);
    end_checks(2, 48, 53, 5, 8'd15);

    // Asynchronous clear during vector 7
    arm();
    push_def();
    do_start();
    guard = 0;
    while (!(m_valid && (m_vec == 8'd7)) && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    check_eq("clr_found_v7", m_vec, 32'd7);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("aclr_vec", m_vec, 32'd0);
    check_eq("aclr_valid", m_valid, 32'd0);
    check_eq("aclr_init", m_init, 32'd0);
    check_eq("aclr_done", m_done, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_clr_valid", m_valid, 32'd0);
    check_eq("post_clr_init", m_init, 32'd0);
    sb.delete();
    arm();
    push_def();
    do_start();
    wait_done(200);
    end_checks(2, 48, 48, 0, 8'd15);

    // Gray, width 3, hold 1
    sel = 1;
    arm();
    foreach (gray_tab[i]) sb.push_back(gray_tab[i]);
    do_start();
    wait_done(100);
    end_checks(2, 8, 8, 0, 8'd4);

    // Maximal LFSR, width 4, hold 1
    sel       = 2;
    lfsr_mode = 1'b1;
    arm();
    do_start();
    wait_done(100);
    check_eq("lfsr_init_cycles", init_cnt, 32'd2);
    check_eq("lfsr_valid_cycles", valid_cnt, 32'd15);
    check_eq("lfsr_run_cycles", run_len, 32'd15);
    check_eq("lfsr_distinct", $countones(seen), 32'd15);
    check_eq("lfsr_done_vec", m_vec, {24'b0, last_vec});
    check_eq("lfsr_done_valid", m_valid, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
